// File: rtl/axis_dma_packetizer_pkg.sv
// Shared types and constants for the DMA packetizer.
// Optional feature macro: DMA_PACKETIZER_TRAILER_EN (adds the end-of-capture trailer word).
package axis_dma_packetizer_pkg;

  localparam logic [15:0] HEADER_MAGIC  = 16'hDA7A;
  localparam logic [15:0] TRAILER_MAGIC = 16'hE0F0;

  // Low 64 bits of the header word; the rest of the bus is zero.
  typedef struct packed {
    logic [15:0] magic;
    logic [15:0] seq;
    logic [31:0] timestamp;
  } header_word_t;

  // Low 64 bits of the trailer word; word_count = header + data words.
  typedef struct packed {
    logic [15:0] magic;
    logic [15:0] seq;
    logic [31:0] word_count;
  } trailer_word_t;

`ifdef DMA_PACKETIZER_TRAILER_EN
  typedef enum logic [1:0] {ST_IDLE, ST_HEADER, ST_DATA, ST_TRAILER} state_t;
`else
  typedef enum logic [1:0] {ST_IDLE, ST_HEADER, ST_DATA} state_t;
`endif

endpackage

// File: rtl/axis_dma_packetizer_if.sv
// AXI-stream style handshake bundle used for the capture input, DMA output and config port.
interface axis_if #(
  parameter int DWIDTH = 128
) ();
  logic              valid;
  logic              ready;
  logic [DWIDTH-1:0] data;
  logic              last;

  modport master (output valid, output data, output last, input ready);
  modport slave  (input valid, input data, input last, output ready);
endinterface

// File: rtl/axis_dma_packetizer_skid_buffer.sv
// Two-entry register slice: registered outputs, full throughput, ready = not full.
module axis_skid_buffer #(
  parameter int DWIDTH = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DWIDTH-1:0] in_data,
  input  logic              in_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DWIDTH-1:0] out_data,
  output logic              out_last,
  output logic              empty
);

  logic [DWIDTH-1:0] mem_data [2];
  logic [1:0]        mem_last;
  logic              wr_ptr;
  logic              rd_ptr;
  logic [1:0]        count;
  logic              push;
  logic              pop;

  assign in_ready  = (count != 2'd2);
  assign out_valid = (count != 2'd0);
  assign empty     = (count == 2'd0);
  assign out_data  = mem_data[rd_ptr];
  assign out_last  = mem_last[rd_ptr];
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  // Storage, pointers and occupancy of the two-entry slice.
  always_ff @(posedge clk) begin
    if (reset) begin
      // NOTE: both entries are cleared because the head entry drives data_out
      // directly and must read as zero straight out of reset.
      for (int i = 0; i < 2; i++) mem_data[i] <= '0;
      mem_last <= '0;
      wr_ptr   <= 1'b0;
      rd_ptr   <= 1'b0;
      count    <= 2'd0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      if (push) begin
        mem_data[wr_ptr] <= in_data;
        mem_last[wr_ptr] <= in_last;
        wr_ptr           <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      count <= count + {1'b0, push} - {1'b0, pop};
    end
  end

endmodule

// File: rtl/axis_dma_packetizer.sv
// Prepends a header to each capture, splits it into DMA packets of at most pkt_len
// words and reports per-capture word/packet counts.
// Optional feature macro: DMA_PACKETIZER_TRAILER_EN (trailer word closes each capture).
module axis_dma_packetizer
  import axis_dma_packetizer_pkg::*;
#(
  parameter int AXI_MM_WIDTH    = 128,
  parameter int PKT_LEN_WIDTH   = 16,
  parameter int DEFAULT_PKT_LEN = 256
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] timestamp_width,
  axis_if.slave       data_in,
  axis_if.master      data_out,
  axis_if.slave       packet_config,
  output logic [31:0] capture_words,
  output logic [31:0] capture_packets,
  output logic        busy
);

  typedef logic [PKT_LEN_WIDTH-1:0] len_t;
  localparam int SKID_W = AXI_MM_WIDTH + 1;  // payload plus end-of-capture marker

  state_t                  state, state_nxt;
  len_t                    pkt_len, pkt_cnt;
  logic [31:0]             word_cnt, pkt_total, pend_words, pend_pkts;
  logic [15:0]             seq;
  logic                    eoc_pending, eoc_pending_nxt;
  logic                    skid_in_valid, skid_in_ready, skid_in_last, skid_in_eoc;
  logic [AXI_MM_WIDTH-1:0] skid_in_data;
  logic [SKID_W-1:0]       skid_out_payload;
  logic                    skid_out_valid, skid_empty;
  logic                    push, eoc_push, eoc_pop, at_boundary;
  header_word_t            hdr;
  logic                    unused_cfg_last;

  assign unused_cfg_last = packet_config.last;
  assign hdr             = {HEADER_MAGIC, seq, timestamp_width};
  assign at_boundary     = (pkt_cnt == pkt_len - len_t'(1));
  assign push            = skid_in_valid & skid_in_ready;
  assign eoc_push        = push & skid_in_eoc;
  assign eoc_pop         = skid_out_valid & data_out.ready & skid_out_payload[AXI_MM_WIDTH];
  assign eoc_pending_nxt = eoc_push | (eoc_pending & ~eoc_pop);
  assign data_out.valid  = skid_out_valid;
  assign data_out.data   = skid_out_payload[AXI_MM_WIDTH-1:0];
  // Config is only taken while nothing of a capture is in flight.
  assign packet_config.ready = (state == ST_IDLE) && skid_empty;

`ifdef DMA_PACKETIZER_TRAILER_EN
  trailer_word_t trl;
  assign trl = {TRAILER_MAGIC, seq, word_cnt};
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE:   if (data_in.valid) state_nxt = ST_HEADER;
      ST_HEADER: if (skid_in_ready) state_nxt = ST_DATA;
      ST_DATA:
        if (data_in.valid && skid_in_ready && data_in.last)
`ifdef DMA_PACKETIZER_TRAILER_EN
          state_nxt = ST_TRAILER;
      ST_TRAILER: if (skid_in_ready) state_nxt = ST_IDLE;
`else
          state_nxt = ST_IDLE;
`endif
      default:   state_nxt = ST_IDLE;
    endcase
  end

  // Output decode: selects header, data or trailer into the skid input and sets tlast.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves one unassigned (no latch).
    skid_in_valid = 1'b0;
    skid_in_data  = '0;
    skid_in_last  = 1'b0;
    skid_in_eoc   = 1'b0;
    data_in.ready = 1'b0;
    unique case (state)
      ST_HEADER: begin
        skid_in_valid = 1'b1;
        skid_in_data  = AXI_MM_WIDTH'(hdr);
        skid_in_last  = at_boundary;
      end
      ST_DATA: begin
        skid_in_valid = data_in.valid;
        data_in.ready = skid_in_ready;
        skid_in_data  = data_in.data;
`ifdef DMA_PACKETIZER_TRAILER_EN
        skid_in_last  = at_boundary;
      end
      ST_TRAILER: begin
        skid_in_valid = 1'b1;
        skid_in_data  = AXI_MM_WIDTH'(trl);
        skid_in_last  = 1'b1;
        skid_in_eoc   = 1'b1;
`else
        skid_in_last  = at_boundary | data_in.last;
        skid_in_eoc   = data_in.last;
`endif
      end
      default: ;
    endcase
  end

  // Packet/word counters, sequence number, config latch, statistics and busy.
  always_ff @(posedge clk) begin
    if (reset) begin
      pkt_len         <= len_t'(DEFAULT_PKT_LEN);
      pkt_cnt         <= '0;
      word_cnt        <= '0;
      pkt_total       <= '0;
      pend_words      <= '0;
      pend_pkts       <= '0;
      seq             <= '0;
      eoc_pending     <= 1'b0;
      capture_words   <= '0;
      capture_packets <= '0;
      busy            <= 1'b0;
    end else begin
      if (packet_config.valid && packet_config.ready)
        pkt_len <= (packet_config.data < len_t'(2)) ? len_t'(2) : packet_config.data;
      if (push) begin
        pkt_cnt <= skid_in_last ? '0 : pkt_cnt + len_t'(1);
        if (skid_in_eoc) begin
          pend_words <= word_cnt + 32'd1;
          pend_pkts  <= pkt_total + 32'd1;
          word_cnt   <= '0;
          pkt_total  <= '0;
          seq        <= seq + 16'd1;
        end else begin
          word_cnt  <= word_cnt + 32'd1;
          pkt_total <= pkt_total + 32'(skid_in_last);
        end
      end
      if (eoc_pop) begin
        capture_words   <= pend_words;
        capture_packets <= pend_pkts;
      end
      eoc_pending <= eoc_pending_nxt;
      busy        <= (state_nxt != ST_IDLE) | eoc_pending_nxt;
    end
  end

  axis_skid_buffer #(.DWIDTH(SKID_W)) u_skid (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (skid_in_valid),
    .in_ready  (skid_in_ready),
    .in_data   ({skid_in_eoc, skid_in_data}),
    .in_last   (skid_in_last),
    .out_valid (skid_out_valid),
    .out_ready (data_out.ready),
    .out_data  (skid_out_payload),
    .out_last  (data_out.last),
    .empty     (skid_empty)
  );

endmodule

// File: tb/tb_axis_dma_packetizer.sv
// Directed bench for axis_dma_packetizer: table of captures plus hand-written
// back-to-back, random-stall and mid-capture reset sequences.
module tb_axis_dma_packetizer;

  localparam int W  = 128;
  localparam int LW = 16;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] timestamp_width = 32'd64;
  logic [31:0] capture_words, capture_packets;
  logic        busy;

  axis_if #(.DWIDTH(W))  din ();
  axis_if #(.DWIDTH(W))  dout ();
  axis_if #(.DWIDTH(LW)) pc ();

  always #5 clk = ~clk;

  axis_dma_packetizer #(.AXI_MM_WIDTH(W), .PKT_LEN_WIDTH(LW), .DEFAULT_PKT_LEN(256)) dut (
    .clk             (clk),
    .reset           (reset),
    .timestamp_width (timestamp_width),
    .data_in         (din),
    .data_out        (dout),
    .packet_config   (pc),
    .capture_words   (capture_words),
    .capture_packets (capture_packets),
    .busy            (busy)
  );

  typedef struct packed { logic [W-1:0] data; logic last; } word_t;
  typedef struct { int cfg; int n; int exp_words; int exp_pkts; logic [63:0] mask; } vec_t;

  word_t       out_q[$];
  word_t       exp_q[$];
  int          checks = 0;
  int          errors = 0;
  bit          rand_ready = 1'b0;
  logic        stall_q = 1'b0;
  logic [W-1:0] hold_data;
  logic        hold_last;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Output ready: always 1, or 50% random when rand_ready is set.
  initial begin
    dout.ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      dout.ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // Output monitor: records accepted words and checks stability under stall.
  always @(negedge clk) begin
    if (reset) begin
      stall_q <= 1'b0;
    end else begin
      if (stall_q) begin
        check("stall_valid", W'(dout.valid), W'(1));
        check("stall_data", dout.data, hold_data);
        check("stall_last", W'(dout.last), W'(hold_last));
      end
      if (dout.valid && dout.ready) out_q.push_back('{dout.data, dout.last});
      stall_q   <= dout.valid && !dout.ready;
      hold_data <= dout.data;
      hold_last <= dout.last;
    end
  end

  task automatic send_capture(input int n, input int base, input bit gaps);
    int t;
    for (int i = 0; i < n; i++) begin
      if (gaps) begin
        repeat ($urandom_range(0, 2)) begin
          din.valid = 1'b0;
          @(posedge clk);
          #1;
        end
      end
      din.valid = 1'b1;
      din.data  = W'(base + i);
      din.last  = (i == n - 1);
      t = 0;
      @(negedge clk);
      while (!din.ready && t < 3000) begin
        @(negedge clk);
        t++;
      end
      if (!din.ready) begin
        check("data_in_ready_timeout", W'(din.ready), W'(1));
        din.valid = 1'b0;
        din.last  = 1'b0;
        return;
      end
      @(posedge clk);
      #1;
    end
    din.valid = 1'b0;
    din.last  = 1'b0;
  endtask

  task automatic write_cfg(input int v);
    int t;
    pc.valid = 1'b1;
    pc.data  = LW'(v);
    t = 0;
    @(negedge clk);
    while (!pc.ready && t < 3000) begin
      @(negedge clk);
      t++;
    end
    check("cfg_ready_idle", W'(pc.ready), W'(1));
    @(posedge clk);
    #1;
    pc.valid = 1'b0;
  endtask

  // Expected stream of one capture; lasts from the hand mask or, for long captures,
  // from the packet rule (boundary every plen words, plus the capture's final word).
  task automatic add_expect(input int seq, input int n, input int base, input int plen,
                            input bit use_mask, input logic [63:0] mask);
    int    total;
    int    cnt;
    word_t w;
    total = n + 1;
`ifdef DMA_PACKETIZER_TRAILER_EN
    total = n + 2;
`endif
    cnt = 0;
    for (int idx = 0; idx < total; idx++) begin
      if (idx == 0)      w.data = W'({16'hDA7A, 16'(seq), 32'd64});
      else if (idx <= n) w.data = W'(base + idx - 1);
      else               w.data = W'({16'hE0F0, 16'(seq), 32'(n + 1)});
      if (use_mask) w.last = mask[idx];
      else          w.last = (cnt == plen - 1) || (idx == total - 1);
      cnt = w.last ? 0 : cnt + 1;
      exp_q.push_back(w);
    end
  endtask

  task automatic drain_and_compare(input string name, input int budget,
                                   input int exp_words, input int exp_pkts);
    int t;
    t = 0;
    while (out_q.size() < exp_q.size() && t < budget) begin
      @(negedge clk);
      t++;
    end
    repeat (3) @(negedge clk);
    check({name, "_count"}, W'(out_q.size()), W'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < out_q.size(); i++) begin
      check($sformatf("%s_data%0d", name, i), out_q[i].data, exp_q[i].data);
      check($sformatf("%s_last%0d", name, i), W'(out_q[i].last), W'(exp_q[i].last));
    end
    out_q.delete();
    exp_q.delete();
    check({name, "_busy"}, W'(busy), W'(0));
    check({name, "_words"}, W'(capture_words), W'(exp_words));
    check({name, "_packets"}, W'(capture_packets), W'(exp_pkts));
  endtask

  initial begin
    vec_t vecs[5];
`ifdef DMA_PACKETIZER_TRAILER_EN
    vecs[0] = '{4, 10, 12, 3, 64'h888};
    vecs[1] = '{4,  7,  9, 3, 64'h188};
    vecs[2] = '{0,  1,  3, 2, 64'h6};
    vecs[3] = '{1,  4,  6, 3, 64'h2A};
    vecs[4] = '{3,  5,  7, 3, 64'h64};
`else
    vecs[0] = '{4, 10, 11, 3, 64'h488};
    vecs[1] = '{4,  7,  8, 2, 64'h88};
    vecs[2] = '{0,  1,  2, 1, 64'h2};
    vecs[3] = '{1,  4,  5, 3, 64'h1A};
    vecs[4] = '{3,  5,  6, 2, 64'h24};
`endif
    din.valid = 1'b0; din.data = '0; din.last = 1'b0;
    pc.valid  = 1'b0; pc.data  = '0; pc.last  = 1'b0;

    // Reset state.
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_valid", W'(dout.valid), W'(0));
    check("rst_data", dout.data, W'(0));
    check("rst_last", W'(dout.last), W'(0));
    check("rst_words", W'(capture_words), W'(0));
    check("rst_packets", W'(capture_packets), W'(0));
    check("rst_busy", W'(busy), W'(0));
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    check("idle_cfg_ready", W'(pc.ready), W'(1));

    // Table of single captures, seq 0..4.
    for (int r = 0; r < 5; r++) begin
      write_cfg(vecs[r].cfg);
      add_expect(r, vecs[r].n, 32'h100 * (r + 1), 0, 1'b1, vecs[r].mask);
      send_capture(vecs[r].n, 32'h100 * (r + 1), 1'b0);
      drain_and_compare($sformatf("vec%0d", r), 2000, vecs[r].exp_words, vecs[r].exp_pkts);
    end

    // Three back-to-back captures with a config write attempted mid-capture.
    write_cfg(4);
    for (int c = 0; c < 3; c++) add_expect(5 + c, 4, 32'h1000 * (c + 1), 4, 1'b0, '0);
    fork
      begin
        for (int c = 0; c < 3; c++) send_capture(4, 32'h1000 * (c + 1), 1'b0);
      end
      begin
        repeat (2) @(negedge clk);
        @(posedge clk);
        #1;
        pc.valid = 1'b1;
        pc.data  = LW'(8);
        repeat (3) begin
          @(negedge clk);
          check("cfg_ready_busy", W'(pc.ready), W'(0));
        end
        @(posedge clk);
        #1;
        pc.valid = 1'b0;
      end
    join
`ifdef DMA_PACKETIZER_TRAILER_EN
    drain_and_compare("b2b", 2000, 6, 2);
`else
    drain_and_compare("b2b", 2000, 5, 2);
`endif

    // Long capture with random output stalls and input gaps.
    write_cfg(16);
    rand_ready = 1'b1;
    add_expect(8, 1000, 32'h10000, 16, 1'b0, '0);
    send_capture(1000, 32'h10000, 1'b1);
`ifdef DMA_PACKETIZER_TRAILER_EN
    drain_and_compare("rand", 20000, 1002, 63);
`else
    drain_and_compare("rand", 20000, 1001, 63);
`endif
    rand_ready = 1'b0;

    // Reset in the middle of a capture.
    @(posedge clk);
    #1;
    din.valid = 1'b1;
    din.data  = W'(32'hBAD);
    din.last  = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("busy_rise", W'(busy), W'(1));
    repeat (5) @(posedge clk);
    #1;
    reset     = 1'b1;
    din.valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("midrst_valid", W'(dout.valid), W'(0));
    check("midrst_last", W'(dout.last), W'(0));
    check("midrst_words", W'(capture_words), W'(0));
    check("midrst_packets", W'(capture_packets), W'(0));
    check("midrst_busy", W'(busy), W'(0));
    @(posedge clk);
    #1;
    reset = 1'b0;
    out_q.delete();
    exp_q.delete();
    add_expect(0, 3, 32'h500, 256, 1'b0, '0);
    send_capture(3, 32'h500, 1'b0);
`ifdef DMA_PACKETIZER_TRAILER_EN
    drain_and_compare("post_rst", 2000, 5, 1);
`else
    drain_and_compare("post_rst", 2000, 4, 1);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Global time limit.
  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
